// File: rtl/pencere_uretici_pkg.sv
// Shared constants and FSM encoding for the 3x3 window generator.
package pencere_uretici_pkg;

   localparam int unsigned PIXEL_BIT   = 8;
   localparam logic        HIGH        = 1'b1;
   localparam logic        LOW         = 1'b0;
   localparam int unsigned PENCERE_BOY = 9;

   typedef enum logic [1:0] {
      PuBos    = 2'd0,
      PuGonder = 2'd1,
      PuBekle  = 2'd2
   } pu_durum_e;

endpackage

// File: rtl/pencere_uretici_satir_tamponu.sv
// One image row of pixels: combinational read of the old value, write-back on the same edge.
module pencere_uretici_satir_tamponu #(
   parameter int unsigned Derinlik = 64,
   parameter int unsigned AdresBit = 6,
   parameter int unsigned VeriBit  = 8
) (
   input  logic                clk_i,
   input  logic                yaz_i,
   input  logic [AdresBit-1:0] adres_i,
   input  logic [VeriBit-1:0]  veri_i,
   output logic [VeriBit-1:0]  veri_o
);

   logic [VeriBit-1:0] bellek_q [Derinlik];

   assign veri_o = bellek_q[adres_i];

   always_ff @(posedge clk_i) begin
      if (yaz_i) begin
         bellek_q[adres_i] <= veri_i;
      end
   end

endmodule

// File: rtl/pencere_uretici.sv
// 3x3 window generator: buffers two rows and serializes each interior neighbourhood as nine
// consecutive beats, followed by one idle cycle for the downstream median unit.
module pencere_uretici
   import pencere_uretici_pkg::*;
#(
   parameter int unsigned GENISLIK  = 64,
   parameter int unsigned YUKSEKLIK = 64
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [PIXEL_BIT-1:0] piksel_i,
   input  logic                 piksel_gecerli_i,
   output logic                 piksel_hazir_o,
   output logic                 medyan_etkin_o,
   output logic [PIXEL_BIT-1:0] medyan_sayi_o,
   output logic                 cerceve_bitti_o
);

   localparam int unsigned SutunBit = $clog2(GENISLIK);
   localparam int unsigned SatirBit = $clog2(YUKSEKLIK);
   localparam logic [SutunBit-1:0] SonSutun = SutunBit'(GENISLIK - 1);
   localparam logic [SatirBit-1:0] SonSatir = SatirBit'(YUKSEKLIK - 1);
   localparam logic [3:0]          SonIndeks = 4'(PENCERE_BOY - 1);

   pu_durum_e             durum_q, durum_d;
   logic [3:0]            indeks_q, indeks_d;
   logic [SutunBit-1:0]   sutun_q, sutun_d;
   logic [SatirBit-1:0]   satir_q, satir_d;
   logic                  cerceve_bitti_q, cerceve_bitti_d;

   logic                  aktarim, pencere_gecerli, son_piksel;
   logic [PIXEL_BIT-1:0]  ust, orta;
   logic [PIXEL_BIT-1:0]  yeni_sutun [3];

   // The oldest window column is never observed, so only the two newest are stored.
   logic [PIXEL_BIT-1:0]  w_q   [3][2];
   logic [PIXEL_BIT-1:0]  golge_q [PENCERE_BOY];

   assign aktarim         = piksel_gecerli_i && piksel_hazir_o;
   assign pencere_gecerli = aktarim && (satir_q >= SatirBit'(2)) && (sutun_q >= SutunBit'(2));
   assign son_piksel      = (sutun_q == SonSutun) && (satir_q == SonSatir);

   pencere_uretici_satir_tamponu #(
      .Derinlik (GENISLIK),
      .AdresBit (SutunBit),
      .VeriBit  (PIXEL_BIT)
   ) u_lb0 (
      .clk_i   (clk_i),
      .yaz_i   (aktarim),
      .adres_i (sutun_q),
      .veri_i  (piksel_i),
      .veri_o  (orta)
   );

   pencere_uretici_satir_tamponu #(
      .Derinlik (GENISLIK),
      .AdresBit (SutunBit),
      .VeriBit  (PIXEL_BIT)
   ) u_lb1 (
      .clk_i   (clk_i),
      .yaz_i   (aktarim),
      .adres_i (sutun_q),
      .veri_i  (orta),
      .veri_o  (ust)
   );

   always_comb begin
      yeni_sutun[0] = ust;
      yeni_sutun[1] = orta;
      yeni_sutun[2] = piksel_i;
   end

   always_comb begin
      sutun_d = sutun_q;
      satir_d = satir_q;
      if (aktarim) begin
         if (sutun_q == SonSutun) begin
            sutun_d = '0;
            satir_d = (satir_q == SonSatir) ? '0 : satir_q + 1'b1;
         end else begin
            sutun_d = sutun_q + 1'b1;
         end
      end
   end

   assign cerceve_bitti_d = aktarim && son_piksel;

   always_comb begin
      durum_d  = durum_q;
      indeks_d = indeks_q;
      unique case (durum_q)
         PuBos: begin
            if (pencere_gecerli) begin
               durum_d  = PuGonder;
               indeks_d = '0;
            end
         end
         PuGonder: begin
            if (indeks_q == SonIndeks) begin
               durum_d = PuBekle;
            end else begin
               indeks_d = indeks_q + 1'b1;
            end
         end
         PuBekle: begin
            if (pencere_gecerli) begin
               durum_d  = PuGonder;
               indeks_d = '0;
            end else begin
               durum_d = PuBos;
            end
         end
         default: durum_d = PuBos;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum_q         <= PuBos;
         indeks_q        <= '0;
         sutun_q         <= '0;
         satir_q         <= '0;
         cerceve_bitti_q <= LOW;
      end else begin
         durum_q         <= durum_d;
         indeks_q        <= indeks_d;
         sutun_q         <= sutun_d;
         satir_q         <= satir_d;
         cerceve_bitti_q <= cerceve_bitti_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (aktarim) begin
         for (int r = 0; r < 3; r++) begin
            w_q[r][0] <= w_q[r][1];
            w_q[r][1] <= yeni_sutun[r];
         end
      end
      if (pencere_gecerli) begin
         for (int r = 0; r < 3; r++) begin
            golge_q[3*r]     <= w_q[r][0];
            golge_q[3*r + 1] <= w_q[r][1];
            golge_q[3*r + 2] <= yeni_sutun[r];
         end
      end
   end

   // Idle value must be zero: the median sorter samples its input every cycle.
   assign piksel_hazir_o  = (durum_q != PuGonder) ? HIGH : LOW;
   assign medyan_etkin_o  = (durum_q == PuGonder) ? HIGH : LOW;
   assign medyan_sayi_o   = medyan_etkin_o ? golge_q[indeks_q] : '0;
   assign cerceve_bitti_o = cerceve_bitti_q;

endmodule

// File: tb/tb_pencere_uretici.sv
// Directed-plus-random bench for pencere_uretici on a 4x4 image with a behavioural frame model.
module tb_pencere_uretici;
   import pencere_uretici_pkg::*;

   localparam int G = 4;
   localparam int Y = 4;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [PIXEL_BIT-1:0] piksel;
   logic                 gecerli;
   logic                 hazir, etkin, bitti;
   logic [PIXEL_BIT-1:0] sayi;

   int n_cmp = 0;
   int n_err = 0;
   int img [Y][G];
   int beats [9];
   int got_med [4];
   bit gaps = 1'b0;

   always #5 clk = ~clk;

   pencere_uretici #(
      .GENISLIK  (G),
      .YUKSEKLIK (Y)
   ) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .piksel_i         (piksel),
      .piksel_gecerli_i (gecerli),
      .piksel_hazir_o   (hazir),
      .medyan_etkin_o   (etkin),
      .medyan_sayi_o    (sayi),
      .cerceve_bitti_o  (bitti)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int med9(input int v [9]);
      int a [9];
      int t;
      a = v;
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return a[4];
   endfunction

   function automatic int model_med(input int r, input int c);
      int v [9];
      for (int k = 0; k < 9; k++) v[k] = img[r-2+k/3][c-2+k%3];
      return med9(v);
   endfunction

   task automatic xfer(input int r, input int c, input int abort_beat, output bit aborted);
      int wait_n;
      aborted = 1'b0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            gecerli = 1'b0;
            piksel  = PIXEL_BIT'($urandom);
            @(negedge clk);
            chk("idle_etkin", etkin, 0);
            chk("idle_sayi", sayi, 0);
         end
      end
      gecerli = 1'b1;
      piksel  = PIXEL_BIT'(img[r][c]);
      wait_n  = 0;
      while (hazir !== 1'b1 && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      chk("hazir_timeout", hazir, 1);
      @(negedge clk);
      gecerli = 1'b0;
      piksel  = PIXEL_BIT'($urandom);
      chk("cerceve_bitti", bitti, (r == Y-1 && c == G-1) ? 1 : 0);
      if (r >= 2 && c >= 2) begin
         for (int k = 0; k < 9; k++) begin
            if (k == abort_beat) begin
               rstn = 1'b0;
               #1;
               chk("abort_etkin", etkin, 0);
               chk("abort_sayi", sayi, 0);
               chk("abort_hazir", hazir, 1);
               chk("abort_bitti", bitti, 0);
               @(negedge clk);
               chk("abort_hold_etkin", etkin, 0);
               rstn = 1'b1;
               aborted = 1'b1;
               return;
            end
            chk("beat_etkin", etkin, 1);
            chk("beat_hazir", hazir, 0);
            chk("beat_sayi", sayi, img[r-2+k/3][c-2+k%3]);
            beats[k] = int'(sayi);
            @(negedge clk);
         end
         chk("bekle_etkin", etkin, 0);
         chk("bekle_sayi", sayi, 0);
         chk("bekle_hazir", hazir, 1);
      end else begin
         chk("kenar_etkin", etkin, 0);
         chk("kenar_sayi", sayi, 0);
      end
   endtask

   task automatic run_frame(input int abort_win);
      int  w;
      bit  ab;
      w = 0;
      for (int r = 0; r < Y; r++) begin
         for (int c = 0; c < G; c++) begin
            xfer(r, c, (w == abort_win && r >= 2 && c >= 2) ? 4 : -1, ab);
            if (r >= 2 && c >= 2) begin
               if (ab) return;
               got_med[w] = med9(beats);
               chk("model_median", got_med[w], model_med(r, c));
               w++;
            end
         end
      end
   endtask

   task automatic fill_ramp(input bit down);
      for (int i = 0; i < Y*G; i++) img[i/G][i%G] = down ? (Y*G - i) : (i + 1);
   endtask

   task automatic expect_meds(input string tag, input int a, input int b, input int c,
                              input int d);
      chk({tag, "_m0"}, got_med[0], a);
      chk({tag, "_m1"}, got_med[1], b);
      chk({tag, "_m2"}, got_med[2], c);
      chk({tag, "_m3"}, got_med[3], d);
   endtask

   initial begin
      rstn    = 1'b0;
      gecerli = 1'b0;
      piksel  = '0;
      #12;
      chk("reset_hazir", hazir, 1);
      chk("reset_etkin", etkin, 0);
      chk("reset_sayi", sayi, 0);
      chk("reset_bitti", bitti, 0);
      @(negedge clk);
      rstn = 1'b1;

      // Back-to-back 1..16, then 16..1 straight after to exercise counter wrap.
      gaps = 1'b0;
      fill_ramp(1'b0);
      run_frame(-1);
      expect_meds("ramp_up", 6, 7, 10, 11);
      fill_ramp(1'b1);
      run_frame(-1);
      expect_meds("ramp_down", 11, 10, 7, 6);

      // Same frame with random valid gaps must give identical medians.
      gaps = 1'b1;
      fill_ramp(1'b0);
      run_frame(-1);
      expect_meds("ramp_gaps", 6, 7, 10, 11);

      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < Y*G; i++) img[i/G][i%G] = int'($urandom_range(0, 255));
         run_frame(-1);
      end

      // Reset in beat 4 of the first window, then a clean frame.
      gaps = 1'b0;
      fill_ramp(1'b0);
      run_frame(0);
      run_frame(-1);
      expect_meds("post_reset", 6, 7, 10, 11);

      for (int i = 0; i < Y*G; i++) img[i/G][i%G] = 255;
      run_frame(-1);
      expect_meds("all255", 255, 255, 255, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
